cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/cmd_decoder_pkg.sv | 32 +++
 rtl/cmd_decoder_timeout_counter.sv | 27 ++
 rtl/cmd_decoder.sv | 132 +++++++++++++
 tb/tb_cmd_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_decoder_pkg.sv
// Shared definitions for the PC command decoder: request codes, error codes,
// FSM state encoding and default timeout.
package cmd_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CMD     = 2'b01,
    ERR_ADDR    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  localparam logic [2:0] CODE_STATUS      = 3'd0;
  localparam logic [2:0] CODE_TEMP        = 3'd1;
  localparam logic [2:0] CODE_HUM         = 3'd2;
  localparam logic [2:0] CODE_CONT_T_ON   = 3'd3;
  localparam logic [2:0] CODE_CONT_H_ON   = 3'd4;
  localparam logic [2:0] CODE_CONT_T_OFF  = 3'd5;
  localparam logic [2:0] CODE_CONT_H_OFF  = 3'd6;

  localparam logic [7:0] REQ_MAX = 8'h06;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/cmd_decoder_timeout_counter.sv
// Saturating cycle counter; expired stays high once TIMEOUT_CYCLES-1 is reached.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  assign expired = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_decoder.sv
// Two-byte PC command decoder: collects {code, address}, validates, hands the
// request to the sensor interface and waits for the reply to complete.
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [7:0]  ADDR_MIN       = 8'h30,
  parameter logic [7:0]  ADDR_MAX       = 8'h39
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cmd_ack,
  input  logic       resp_done,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [7:0] cmd_addr,
  output logic       cont_temp,
  output logic       cont_hum,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       busy
);

  state_t     state;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic       timer_clear;
  logic       timer_enable;
  logic       expired;

  // The timer only runs in the two waiting states and sits at zero elsewhere,
  // so every entry into a waiting state starts from a cleared count.
  assign timer_enable = (state == S_GET_ADDR) || (state == S_WAIT_DONE);
  assign timer_clear  = !timer_enable;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      byte0     <= '0;
      byte1     <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_addr  <= '0;
      cont_temp <= 1'b0;
      cont_hum  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            byte0 <= rx_data;
            state <= S_GET_ADDR;
            busy  <= 1'b1;
          end
        end
        S_GET_ADDR: begin
          if (rx_valid) begin
            byte1 <= rx_data;
            state <= S_CHECK;
          end else if (expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (byte0 > REQ_MAX) begin
            err_valid <= 1'b1;
            err_code  <= ERR_CMD;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else if (byte1 < ADDR_MIN || byte1 > ADDR_MAX) begin
            err_valid <= 1'b1;
            err_code  <= ERR_ADDR;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            cmd_valid <= 1'b1;
            cmd_code  <= byte0[2:0];
            cmd_addr  <= byte1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ack) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_DONE;
            case (cmd_code)
              CODE_CONT_T_ON:  cont_temp <= 1'b1;
              CODE_CONT_H_ON:  cont_hum  <= 1'b1;
              CODE_CONT_T_OFF: cont_temp <= 1'b0;
              CODE_CONT_H_OFF: cont_hum  <= 1'b0;
              default: ;
            endcase
          end
        end
        S_WAIT_DONE: begin
          if (resp_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: vector table of frames plus hand-written
// timeout, reset and stray-input sequences.
module tb_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ack;
  logic       resp_done;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] cmd_addr;
  logic       cont_temp;
  logic       cont_hum;
  logic       err_valid;
  logic [1:0] err_code;
  logic       busy;

  int total = 0;
  int bad   = 0;

  cmd_decoder #(
    .TIMEOUT_CYCLES(16),
    .ADDR_MIN      (8'h30),
    .ADDR_MAX      (8'h39)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_ack  (cmd_ack),
    .resp_done(resp_done),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_addr (cmd_addr),
    .cont_temp(cont_temp),
    .cont_hum (cont_hum),
    .err_valid(err_valid),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       ok;
    logic [1:0] err;
    logic [2:0] code;
    logic       ct;
    logic       ch;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Returns one negedge after the byte1 edge; cmd_valid/err appear one edge later.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
    send_byte(b0);
    send_byte(b1);
  endtask

  task automatic ack_then_done;
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; cmd_ack = 1'b0; resp_done = 1'b0;
    vecs[0]  = '{8'h01, 8'h33, 1'b1, 2'b00, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h30, 1'b1, 2'b00, 3'd3, 1'b1, 1'b0};
    vecs[2]  = '{8'h04, 8'h39, 1'b1, 2'b00, 3'd4, 1'b1, 1'b1};
    vecs[3]  = '{8'h00, 8'h30, 1'b1, 2'b00, 3'd0, 1'b1, 1'b1};
    vecs[4]  = '{8'h07, 8'h3A, 1'b0, 2'b01, 3'd0, 1'b1, 1'b1};
    vecs[5]  = '{8'h05, 8'h30, 1'b1, 2'b00, 3'd5, 1'b0, 1'b1};
    vecs[6]  = '{8'h02, 8'h41, 1'b0, 2'b10, 3'd0, 1'b0, 1'b1};
    vecs[7]  = '{8'hFF, 8'h35, 1'b0, 2'b01, 3'd0, 1'b0, 1'b1};
    vecs[8]  = '{8'h06, 8'h2F, 1'b0, 2'b10, 3'd0, 1'b0, 1'b1};
    vecs[9]  = '{8'h06, 8'h30, 1'b1, 2'b00, 3'd6, 1'b0, 1'b0};
    vecs[10] = '{8'h02, 8'h3A, 1'b0, 2'b10, 3'd0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {30'd0, cont_temp, cont_hum}, 0);
    chk("rst_err", {29'd0, err_valid, err_code}, 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].b0, vecs[i].b1);
      chk($sformatf("v%0d_check_quiet", i), {30'd0, cmd_valid, err_valid}, 0);
      @(negedge clk);
      if (vecs[i].ok) begin
        chk($sformatf("v%0d_valid", i), 32'(cmd_valid), 1);
        chk($sformatf("v%0d_code", i), 32'(cmd_code), 32'(vecs[i].code));
        chk($sformatf("v%0d_addr", i), 32'(cmd_addr), 32'(vecs[i].b1));
        chk($sformatf("v%0d_busy", i), 32'(busy), 1);
        @(negedge clk);
        chk($sformatf("v%0d_hold", i), 32'(cmd_valid), 1);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk($sformatf("v%0d_drop", i), 32'(cmd_valid), 0);
        chk($sformatf("v%0d_flags", i), {30'd0, cont_temp, cont_hum}, {30'd0, vecs[i].ct, vecs[i].ch});
        chk($sformatf("v%0d_busy_wait", i), 32'(busy), 1);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
        chk($sformatf("v%0d_idle", i), 32'(busy), 0);
      end else begin
        chk($sformatf("v%0d_err_valid", i), 32'(err_valid), 1);
        chk($sformatf("v%0d_err_code", i), 32'(err_code), 32'(vecs[i].err));
        chk($sformatf("v%0d_no_cmd", i), {30'd0, cmd_valid, busy}, 0);
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", i), 32'(err_valid), 0);
        chk($sformatf("v%0d_err_held", i), 32'(err_code), 32'(vecs[i].err));
        chk($sformatf("v%0d_flags", i), {30'd0, cont_temp, cont_hum}, {30'd0, vecs[i].ct, vecs[i].ch});
      end
    end

    // Inter-byte timeout: byte0 edge is E0, error lands on E16.
    send_byte(8'h01);
    repeat (15) @(negedge clk);
    chk("to_addr_early", {30'd0, err_valid, busy}, 1);
    @(negedge clk);
    chk("to_addr_err", {29'd0, err_valid, err_code}, 7);
    chk("to_addr_idle", 32'(busy), 0);

    // Byte1 on the expiry cycle is accepted.
    send_byte(8'h01);
    repeat (15) @(negedge clk);
    rx_data = 8'h32; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("edge_addr_no_err", {30'd0, err_valid, busy}, 1);
    @(negedge clk);
    chk("edge_addr_cmd", {23'd0, cmd_valid, cmd_addr}, {23'd0, 1'b1, 8'h32});

    // Response-wait timeout after ack.
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    repeat (15) @(negedge clk);
    chk("to_done_early", {30'd0, err_valid, busy}, 1);
    @(negedge clk);
    chk("to_done_err", {29'd0, err_valid, err_code}, 7);
    chk("to_done_idle", 32'(busy), 0);

    // resp_done on the expiry cycle wins; err_code still holds the old timeout.
    send_frame(8'h00, 8'h31);
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    repeat (15) @(negedge clk);
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
    chk("edge_done_no_err", {30'd0, err_valid, busy}, 0);

    // Stray byte while ISSUE holds the request.
    send_frame(8'h01, 8'h34);
    @(negedge clk);
    rx_data = 8'h37; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_rx_hold", {20'd0, cmd_valid, cmd_code, cmd_addr}, {20'd0, 1'b1, 3'd1, 8'h34});
    ack_then_done;
    chk("stray_rx_idle", 32'(busy), 0);

    // Stray ack while idle changes nothing.
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk("stray_ack", {29'd0, busy, cont_temp, cont_hum}, 0);

    // Reset while cmd_valid is high, colliding with ack and a new byte.
    send_frame(8'h04, 8'h30);
    @(negedge clk);
    ack_then_done;
    chk("pre_rst_hum", 32'(cont_hum), 1);
    send_frame(8'h02, 8'h35);
    @(negedge clk);
    chk("pre_rst_valid", 32'(cmd_valid), 1);
    reset = 1'b1; cmd_ack = 1'b1; rx_data = 8'h01; rx_valid = 1'b1; resp_done = 1'b1;
    @(negedge clk);
    reset = 1'b0; cmd_ack = 1'b0; rx_valid = 1'b0; resp_done = 1'b0;
    chk("mid_rst_cmd", {20'd0, cmd_valid, cmd_code, cmd_addr}, 0);
    chk("mid_rst_misc", {26'd0, cont_temp, cont_hum, err_valid, err_code, busy}, 0);
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
